// File: rtl/banked_memory_port.sv
// Word memory with independent write/read request channels, byte strobes, a fixed-latency
// read pipeline and a show-ahead response FIFO. Writes win the single RAM port.
module banked_memory_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 655360,
  parameter int READ_LATENCY   = 3,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_error,
  output logic                    addr_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PIPE  = READ_LATENCY - 1;
  localparam int PW    = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(RSP_FIFO_DEPTH + 1);

  function automatic logic f_addr_err(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] idx;
    idx = addr >> SHIFT;
    return ((addr & ADDR_WIDTH'(BYTES - 1)) != '0) || (idx >= ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDXW-1:0] f_word(input logic [ADDR_WIDTH-1:0] addr);
    return IDXW'(addr >> SHIFT);
  endfunction

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  r_run;
  logic                  r_addr_error;
  logic                  r_vld_p  [PIPE];
  logic                  r_err_p  [PIPE];
  logic [DATA_WIDTH-1:0] r_data_p [PIPE];
  logic [CW-1:0]         r_outstanding;

  logic [DATA_WIDTH-1:0] r_fifo_data [RSP_FIFO_DEPTH];
  logic                  r_fifo_err  [RSP_FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic                  r_last_err;

  logic                  w_wr_fire;
  logic                  w_wr_err;
  logic [IDXW-1:0]       w_wr_idx;
  logic                  w_rd_fire;
  logic                  w_rd_err;
  logic [IDXW-1:0]       w_rd_idx;
  logic                  w_push;
  logic                  w_pop;

  assign w_wr_err  = f_addr_err(wr_addr);
  assign w_wr_idx  = f_word(wr_addr);
  assign w_rd_err  = f_addr_err(rd_addr);
  assign w_rd_idx  = f_word(rd_addr);

  assign wr_ready  = r_run;
  assign w_wr_fire = wr_valid & r_run;

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  // A pop in the same cycle frees a slot, so a full pipeline still accepts.
  assign rd_ready  = r_run & ~wr_valid & ((r_outstanding < CW'(RSP_FIFO_DEPTH)) | w_pop);
  assign w_rd_fire = rd_valid & rd_ready;
  assign w_push    = r_vld_p[PIPE-1];

  assign rsp_data   = rsp_valid ? r_fifo_data[r_rptr] : r_last_data;
  assign rsp_error  = rsp_valid ? r_fifo_err[r_rptr]  : r_last_err;
  assign addr_error = r_addr_error;

  // RAM write port: erroneous writes never touch storage
  always_ff @(posedge clk) begin
    if (w_wr_fire && !w_wr_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Stage p0: RAM read at the accept edge; later stages are pure delay to the FIFO
  always_ff @(posedge clk) begin
    r_err_p[0] <= w_rd_err;
    if (w_rd_fire && !w_rd_err) r_data_p[0] <= r_mem[w_rd_idx];
    for (int k = 1; k < PIPE; k++) begin
      r_err_p[k]  <= r_err_p[k-1];
      r_data_p[k] <= r_data_p[k-1];
    end
    if (w_push) begin
      r_fifo_data[r_wptr] <= r_err_p[PIPE-1] ? '0 : r_data_p[PIPE-1];
      r_fifo_err[r_wptr]  <= r_err_p[PIPE-1];
    end
  end

  // Control: valids, pointers, occupancy and the empty-FIFO output hold register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run         <= 1'b0;
      r_addr_error  <= 1'b0;
      for (int k = 0; k < PIPE; k++) r_vld_p[k] <= 1'b0;
      r_outstanding <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_last_data   <= '0;
      r_last_err    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if ((w_wr_fire && w_wr_err) || (w_rd_fire && w_rd_err)) r_addr_error <= 1'b1;

      r_vld_p[0] <= w_rd_fire;
      for (int k = 1; k < PIPE; k++) r_vld_p[k] <= r_vld_p[k-1];

      case ({w_rd_fire, w_pop})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_push) r_wptr <= f_ptr_inc(r_wptr);
      if (w_pop) begin
        r_rptr      <= f_ptr_inc(r_rptr);
        r_last_data <= r_fifo_data[r_rptr];
        r_last_err  <= r_fifo_err[r_rptr];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_banked_memory_port.sv
// Directed bench for banked_memory_port: table of write/read vectors plus hand sequences
// for backpressure, write priority and reset with reads in flight.
module tb_banked_memory_port;

  localparam int DEPTH = 655360;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        addr_error;

  int checks = 0;
  int errors = 0;

  banked_memory_port #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .READ_LATENCY(3), .RSP_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .addr_error(addr_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic        do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] ra;
    logic [31:0] ed;
    logic        ee;
    logic        es;
  } vec_t;

  vec_t vt [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_strb  = s;
    tick();
    wr_valid = 1'b0;
    wr_strb  = 4'h0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic e,
                         output int lat);
    int guard;
    guard    = 0;
    rd_valid = 1'b1;
    rd_addr  = a;
    #1;
    while (!rd_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("rd_accept", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    d = rsp_data;
    e = rsp_error;
    tick();
  endtask

  logic [31:0] la  [6];
  logic [31:0] led [6];
  logic        lee [6];

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          nacc;
    int          nrsp;
    logic        stale;

    vt[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[1] = '{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h20, 32'h11223344, 1'b0, 1'b0};
    vt[2] = '{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h20, 32'h11BB33DD, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'h10, 32'hCAFEF00D, 4'h0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h20, 32'h55667788, 4'h2, 32'h20, 32'h11BB77DD, 1'b0, 1'b0};
    vt[5] = '{1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1};
    vt[6] = '{1'b1, 32'(4*DEPTH), 32'h12345678, 4'hF, 32'h13, 32'h0, 1'b1, 1'b1};
    vt[7] = '{1'b1, 32'(4*DEPTH-4), 32'h0BADCAFE, 4'hF, 32'(4*DEPTH-4), 32'h0BADCAFE, 1'b0, 1'b1};
    vt[8] = '{1'b0, 32'h0, 32'h0, 4'h0, 32'(4*DEPTH), 32'h0, 1'b1, 1'b1};

    la[0] = 32'h10;           led[0] = 32'hDEADBEEF; lee[0] = 1'b0;
    la[1] = 32'h20;           led[1] = 32'h11BB77DD; lee[1] = 1'b0;
    la[2] = 32'(4*DEPTH-4);   led[2] = 32'h0BADCAFE; lee[2] = 1'b0;
    la[3] = 32'h13;           led[3] = 32'h0;        lee[3] = 1'b1;
    la[4] = 32'h10;           led[4] = 32'hDEADBEEF; lee[4] = 1'b0;
    la[5] = 32'h20;           led[5] = 32'h11BB77DD; lee[5] = 1'b0;

    reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b1;
    #3;
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_addr_error", 64'(addr_error), 64'd0);
    #19 reset = 1'b1;
    tick();
    chk("run_wr_ready", 64'(wr_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].do_wr) do_write(vt[i].wa, vt[i].wd, vt[i].ws);
      do_read(vt[i].ra, d, e, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_data", i), 64'(d), 64'(vt[i].ed));
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vt[i].ee));
      chk($sformatf("vec%0d_sticky", i), 64'(addr_error), 64'(vt[i].es));
    end

    // Backpressure: six back-to-back reads with the consumer stalled
    rsp_ready = 1'b0;
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      rd_valid = 1'b1;
      rd_addr  = la[nacc];
      #1;
      if (rd_ready) nacc++;
      tick();
    end
    chk("bp_accepted", 64'(nacc), 64'd4);
    chk("bp_rd_ready_low", 64'(rd_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_data", 64'(rsp_data), 64'(led[0]));
      tick();
    end
    rsp_ready = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 40 && nrsp < 6; c++) begin
      if (nacc < 6) begin
        rd_valid = 1'b1;
        rd_addr  = la[nacc];
      end else begin
        rd_valid = 1'b0;
      end
      #1;
      if (rd_valid && rd_ready) nacc++;
      if (rsp_valid) begin
        chk($sformatf("bp_rsp%0d_data", nrsp), 64'(rsp_data), 64'(led[nrsp]));
        chk($sformatf("bp_rsp%0d_err", nrsp), 64'(rsp_error), 64'(lee[nrsp]));
        nrsp++;
      end
      tick();
    end
    rd_valid = 1'b0;
    chk("bp_total_accepted", 64'(nacc), 64'd6);
    chk("bp_total_responses", 64'(nrsp), 64'd6);

    // Write priority: simultaneous requests for three cycles
    for (int c = 0; c < 3; c++) begin
      wr_valid = 1'b1; wr_addr = 32'h40; wr_data = 32'(c + 1); wr_strb = 4'hF;
      rd_valid = 1'b1; rd_addr = 32'h40;
      #1;
      chk("prio_rd_ready", 64'(rd_ready), 64'd0);
      chk("prio_wr_ready", 64'(wr_ready), 64'd1);
      tick();
    end
    wr_valid = 1'b0;
    wr_strb  = 4'h0;
    #1;
    chk("prio_rd_after", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("prio_latency", 64'(lat), 64'd3);
    chk("prio_data", 64'(rsp_data), 64'd3);
    tick();

    // Reset with two reads in flight
    chk("pre_reset_sticky", 64'(addr_error), 64'd1);
    rd_valid = 1'b1;
    rd_addr  = 32'h10;
    tick();
    rd_addr  = 32'h20;
    tick();
    rd_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rsp_data", 64'(rsp_data), 64'd0);
    chk("async_addr_error", 64'(addr_error), 64'd0);
    chk("async_rd_ready", 64'(rd_ready), 64'd0);
    chk("async_wr_ready", 64'(wr_ready), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      tick();
      if (rsp_valid) stale = 1'b1;
    end
    chk("no_stale_rsp", 64'(stale), 64'd0);
    do_read(32'h10, d, e, lat);
    chk("retain_0x10", 64'(d), 64'hDEADBEEF);
    do_read(32'h40, d, e, lat);
    chk("retain_0x40", 64'(d), 64'd3);
    chk("post_reset_sticky", 64'(addr_error), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
